frame_capture_rx: RTL



---
 rtl/frame_capture_rx.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/frame_capture_rx.sv
// Armed single-frame capture sink: writes one fval/lval pixel frame into a RAM write port and
// checks its geometry. Define FRAME_CAPTURE_SUM_EN to enable the frame_sum pixel checksum.
module frame_capture_rx #(
   parameter int unsigned WIDTH  = 640,
   parameter int unsigned HEIGHT = 512,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 19
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              arm,
   input  logic              b_fval,
   input  logic              b_lval,
   input  logic [DATA_W-1:0] in_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic [15:0]       line_cnt,
   output logic [15:0]       last_len,
   output logic              err_width,
   output logic              err_height,
   output logic [31:0]       frame_sum
);

   typedef enum logic [1:0] {StIdle, StWaitSof, StCapture, StDone} state_e;

   localparam logic [15:0]       WidthC  = 16'(WIDTH);
   localparam logic [15:0]       HeightC = 16'(HEIGHT);
   localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(WIDTH);

   state_e              state_q, state_d;
   logic                fval_q, lval_q;
   logic [15:0]         col_q, col_d;
   logic [15:0]         row_q, row_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [15:0]         line_cnt_q, line_cnt_d;
   logic [15:0]         last_len_q, last_len_d;
   logic                err_w_q, err_w_d;
   logic                err_h_q, err_h_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                done_q, done_d;

   logic fval_rise, fval_fall, lval_fall;
   logic arm_ok, active, sample, line_close, frame_end, in_range;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign fval_rise = b_fval & ~fval_q;
   assign fval_fall = ~b_fval & fval_q;
   assign lval_fall = ~b_lval & lval_q;
   assign arm_ok    = arm & ((state_q == StIdle) | (state_q == StDone));
   // The start-of-frame cycle itself may carry the first pixel.
   assign active    = (state_q == StCapture) | ((state_q == StWaitSof) & fval_rise);
   assign sample    = active & b_fval & b_lval;
   // col_q != 0 keeps a line that never sampled a pixel from being counted.
   assign line_close = (state_q == StCapture) & (col_q != 16'd0) &
                       ((lval_fall & b_fval) | (fval_fall & lval_q));
   assign frame_end = (state_q == StCapture) & fval_fall;
   assign in_range  = (col_q < WidthC) & (row_q < HeightC);

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      base_d     = base_q;
      line_cnt_d = line_cnt_q;
      last_len_d = last_len_q;
      err_w_d    = err_w_q;
      err_h_d    = err_h_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      done_d     = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (arm) begin
               state_d    = StWaitSof;
               col_d      = '0;
               row_d      = '0;
               base_d     = '0;
               line_cnt_d = '0;
               last_len_d = '0;
               err_w_d    = 1'b0;
               err_h_d    = 1'b0;
            end
         end
         StWaitSof: if (fval_rise) state_d = StCapture;
         StCapture: if (frame_end) state_d = StDone;
         default:   state_d = StIdle;
      endcase

      if (sample) begin
         col_d = sat_inc(col_q);
         if (in_range) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q + ADDR_W'(col_q);
            wr_data_d = in_data;
         end
      end

      if (line_close) begin
         last_len_d = col_q;
         line_cnt_d = sat_inc(line_cnt_q);
         row_d      = sat_inc(row_q);
         col_d      = '0;
         if (row_q < HeightC) base_d = base_q + RowStep;
         if (col_q != WidthC) err_w_d = 1'b1;
      end

      if (frame_end) begin
         done_d = 1'b1;
         if (line_cnt_d != HeightC) err_h_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         fval_q     <= 1'b0;
         lval_q     <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         base_q     <= '0;
         line_cnt_q <= '0;
         last_len_q <= '0;
         err_w_q    <= 1'b0;
         err_h_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fval_q     <= b_fval;
         lval_q     <= b_lval;
         col_q      <= col_d;
         row_q      <= row_d;
         base_q     <= base_d;
         line_cnt_q <= line_cnt_d;
         last_len_q <= last_len_d;
         err_w_q    <= err_w_d;
         err_h_q    <= err_h_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         done_q     <= done_d;
      end
   end

`ifdef FRAME_CAPTURE_SUM_EN
   logic [31:0] sum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else if (arm_ok) begin
         sum_q <= '0;
      end else if (sample) begin
         sum_q <= sum_q + 32'(in_data);
      end
   end

   assign frame_sum = sum_q;
`else
   assign frame_sum = '0;
`endif

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = (state_q == StWaitSof) | (state_q == StCapture);
   assign frame_done = done_q;
   assign line_cnt   = line_cnt_q;
   assign last_len   = last_len_q;
   assign err_width  = err_w_q;
   assign err_height = err_h_q;

endmodule
